sb_i2c_ctrl: RTL and testbench
==============================

# sb_i2c_ctrl

Sequencer that sits directly upstream of the iCE40 hard I2C primitive and owns its system-bus (SB) port. It accepts one-byte I2C master commands from fabric logic, translates each into the required SB register writes, reads and status polls, and returns the received byte plus acknowledge/error status. After reset it initialises the primitive (enable, prescaler) before reporting ready.

## Interface
- `BUS_ADDR74`, 4'b0001: upper SB address nibble of the target I2C primitive.
- `PRESCALE`, 10'd30: I2C clock divider written to I2CBRMSB[1:0]/I2CBRLSB.
- `POLL_LIMIT`, 16'd4095: max status polls per wait (used only with timeout build).
- `clk`  in  1  system clock, also drives `sb_clk` domain of the primitive.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_read` in 1: 1 = read byte, 0 = write byte.
- `cmd_start` in 1, `cmd_stop` in 1: issue START before / STOP after byte.
- `cmd_nack` in 1: on read, master NACKs the byte (last byte).
- `cmd_data` in 8: write byte.
- `rsp_valid` out 1 (single-cycle pulse), `rsp_data` out 8, `rsp_nack` out 1 (slave NACK on write), `rsp_error` out 1 (arbitration lost or timeout).
- `sb_stb` out 1, `sb_rw` out 1 (1 = write), `sb_adr` out 8, `sb_dat_w` out 8, `sb_dat_r` in 8, `sb_ack` in 1: SB master port.

## Operation
- Register low nibbles: CR1=8, CMDR=9, BRLSB=A, BRMSB=B, SR=C, TXDR=D, RXDR=E; `sb_adr` = {BUS_ADDR74, nibble}.
- SR bits: TIP=7, BUSY=6, RARC=5, ARBL=3, TRRDY=2. CMDR bits: STA=7, STO=6, RD=5, WR=4, ACK=3.
- States: INIT_BRL, INIT_BRM, INIT_CR1, IDLE, WR_TX, WR_CMD, POLL_RDY, RD_RX, STOP_CMD, POLL_IDLE, RESP.
- Init: write BRLSB=PRESCALE[7:0], BRMSB={6'b0,PRESCALE[9:8]}, CR1=8'h80; then IDLE.
- IDLE: `cmd_ready`=1; accept latches all cmd fields; `cmd_ready` drops the cycle after accept.
- Write: WR_TX (TXDR=data), WR_CMD (CMDR={start,0,0,1,0,000}), POLL_RDY until TRRDY=1; capture RARC into `rsp_nack`.
- Read: WR_CMD (CMDR={start,0,1,0,nack,000}), POLL_RDY, RD_RX reads RXDR into `rsp_data`.
- ARBL=1 in any poll: set `rsp_error`, skip STOP, go RESP.
- If `cmd_stop`: STOP_CMD (CMDR=8'h40), POLL_IDLE until BUSY=0.
- RESP: one-cycle `rsp_valid`; return to IDLE.
- `rsp_data`/`rsp_nack`/`rsp_error` hold until next RESP.

## Timing
- Reset values: `cmd_ready`=0, `rsp_valid`=0, `rsp_*`=0, `sb_stb`=0, `sb_rw`=0, `sb_adr`=0, `sb_dat_w`=0.
- SB cycle: `sb_stb`,`sb_rw`,`sb_adr`,`sb_dat_w` registered and held stable until `sb_ack` sampled high; `sb_stb` low the following cycle; at least one idle cycle between SB cycles.
- Read data captured on the cycle `sb_ack`=1.
- `cmd_ready` first rises no earlier than 3 SB cycles after reset release.
- Reset mid-transaction: all outputs to reset values next edge; init sequence reruns; primitive state not otherwise recovered.
- `cmd_valid` while `cmd_ready`=0 is ignored (held by source).

## Configuration
- `SB_I2C_CTRL_TIMEOUT_EN` defined: counter aborts any SB cycle with no `sb_ack` within 255 cycles and any poll loop exceeding POLL_LIMIT reads; abort sets `rsp_error`, drops `sb_stb`, goes RESP (during init: restarts init).
- Undefined: waits indefinitely; POLL_LIMIT unused; counters not synthesised.

## Structure
- Package `sb_i2c_pkg`: register nibble constants, SR/CMDR bit indices, state enum.
- Sub-module `sb_bus_master`: single SB transaction (req/done handshake, strobe hold, read capture, optional ack timeout).

## Test plan
- Reset release -> SB writes A=30, B=0, 8=80 to addresses 0x1A,0x1B,0x18, then `cmd_ready`=1.
- Write 0xA5 start, slave ACK -> TXDR=A5, CMDR=90, polls until TRRDY, `rsp_valid` with `rsp_nack`=0, `rsp_error`=0.
- Write with stop, model RARC=1 -> CMDR=10, then CMDR=40, polls BUSY to 0, `rsp_nack`=1.
- Read with nack+stop, RXDR=0x3C -> CMDR=28, read 0x1E, CMDR=40, `rsp_data`=3C.
- ARBL=1 on first poll -> no STOP write, `rsp_error`=1.
- Timeout build, `sb_ack` held low -> abort after 255 cycles, `rsp_error`=1, `sb_stb`=0; reset asserted mid-cycle -> init sequence restarts.

Source files
------------

// File: rtl/sb_i2c_pkg.sv
// Shared constants for the iCE40 hard-I2C sequencer: SB register map,
// status/command bit positions and the sequencer state encoding.
package sb_i2c_pkg;

   localparam logic [3:0] REG_CR1   = 4'h8;
   localparam logic [3:0] REG_CMDR  = 4'h9;
   localparam logic [3:0] REG_BRLSB = 4'hA;
   localparam logic [3:0] REG_BRMSB = 4'hB;
   localparam logic [3:0] REG_SR    = 4'hC;
   localparam logic [3:0] REG_TXDR  = 4'hD;
   localparam logic [3:0] REG_RXDR  = 4'hE;

   localparam int SR_TIP   = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_RARC  = 5;
   localparam int SR_ARBL  = 3;
   localparam int SR_TRRDY = 2;

   localparam int CMDR_STA = 7;
   localparam int CMDR_STO = 6;
   localparam int CMDR_RD  = 5;
   localparam int CMDR_WR  = 4;
   localparam int CMDR_ACK = 3;

   localparam logic [7:0] CR1_ENABLE = 8'h80;

   typedef enum logic [3:0] {
      INIT_BRL,
      INIT_BRM,
      INIT_CR1,
      IDLE,
      WR_TX,
      WR_CMD,
      POLL_RDY,
      RD_RX,
      STOP_CMD,
      POLL_IDLE,
      RESP
   } state_t;

   function automatic logic [7:0] cmdr_byte(
      input logic sta,
      input logic sto,
      input logic rd,
      input logic wr,
      input logic ack
   );
      logic [7:0] b;
      b = 8'h00;
      b[CMDR_STA] = sta;
      b[CMDR_STO] = sto;
      b[CMDR_RD]  = rd;
      b[CMDR_WR]  = wr;
      b[CMDR_ACK] = ack;
      return b;
   endfunction

endpackage

// File: rtl/sb_bus_master.sv
// One SB transaction per request: registered strobe held until ack.
// SB_I2C_CTRL_TIMEOUT_EN adds a 255-cycle ack timeout.
module sb_bus_master
   import sb_i2c_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_req,
   input  logic       i_rw,
   input  logic [7:0] i_adr,
   input  logic [7:0] i_dat_w,
   output logic       o_done,
   output logic       o_timeout,
   output logic [7:0] o_rdata,
   output logic       o_sb_stb,
   output logic       o_sb_rw,
   output logic [7:0] o_sb_adr,
   output logic [7:0] o_sb_dat_w,
   input  logic [7:0] i_sb_dat_r,
   input  logic       i_sb_ack
);

   logic       r_stb;
   logic       r_rw;
   logic [7:0] r_adr;
   logic [7:0] r_dat;
   logic [7:0] r_rdata;
   logic       r_done;
   logic       r_to;

`ifdef SB_I2C_CTRL_TIMEOUT_EN
   logic [7:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_reset || !r_stb) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end
`endif

   // The done cycle blocks a new request, guaranteeing an idle gap.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stb   <= 1'b0;
         r_rw    <= 1'b0;
         r_adr   <= 8'h00;
         r_dat   <= 8'h00;
         r_rdata <= 8'h00;
         r_done  <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_to   <= 1'b0;
         if (r_stb) begin
            if (i_sb_ack) begin
               r_stb  <= 1'b0;
               r_done <= 1'b1;
               if (!r_rw) begin
                  r_rdata <= i_sb_dat_r;
               end
            end
`ifdef SB_I2C_CTRL_TIMEOUT_EN
            else if (r_cnt == 8'd254) begin
               r_stb  <= 1'b0;
               r_done <= 1'b1;
               r_to   <= 1'b1;
            end
`endif
         end else if (i_req && !r_done) begin
            r_stb <= 1'b1;
            r_rw  <= i_rw;
            r_adr <= i_adr;
            r_dat <= i_dat_w;
         end
      end
   end

   assign o_done     = r_done;
   assign o_timeout  = r_to;
   assign o_rdata    = r_rdata;
   assign o_sb_stb   = r_stb;
   assign o_sb_rw    = r_rw;
   assign o_sb_adr   = r_adr;
   assign o_sb_dat_w = r_dat;

endmodule

// File: rtl/sb_i2c_ctrl.sv
// Byte-level I2C master sequencer driving the iCE40 hard I2C SB port.
// SB_I2C_CTRL_TIMEOUT_EN enables SB ack and status-poll timeouts.
module sb_i2c_ctrl
   import sb_i2c_pkg::*;
#(
   parameter logic [3:0]  BUS_ADDR74 = 4'b0001,
   parameter logic [9:0]  PRESCALE   = 10'd30,
   parameter logic [15:0] POLL_LIMIT = 16'd4095
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_read,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_nack,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_nack,
   output logic       rsp_error,
   output logic       sb_stb,
   output logic       sb_rw,
   output logic [7:0] sb_adr,
   output logic [7:0] sb_dat_w,
   input  logic [7:0] sb_dat_r,
   input  logic       sb_ack
);

   state_t     r_state;
   state_t     w_next;

   logic       r_read;
   logic       r_start;
   logic       r_stop;
   logic       r_nack;
   logic [7:0] r_data;
   logic [7:0] r_rx;
   logic       r_nk_acc;
   logic       r_err_acc;
   logic [7:0] r_rsp_data;
   logic       r_rsp_nack;
   logic       r_rsp_error;

   logic       w_req;
   logic       w_rw;
   logic [3:0] w_nib;
   logic [7:0] w_wdat;
   logic       w_accept;
   logic       w_set_err;
   logic       w_set_nack;
   logic       w_cap_rx;
   logic       w_done;
   logic       w_to;
   logic [7:0] w_rd;

   sb_bus_master u_bus (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_req      (w_req),
      .i_rw       (w_rw),
      .i_adr      ({BUS_ADDR74, w_nib}),
      .i_dat_w    (w_wdat),
      .o_done     (w_done),
      .o_timeout  (w_to),
      .o_rdata    (w_rd),
      .o_sb_stb   (sb_stb),
      .o_sb_rw    (sb_rw),
      .o_sb_adr   (sb_adr),
      .o_sb_dat_w (sb_dat_w),
      .i_sb_dat_r (sb_dat_r),
      .i_sb_ack   (sb_ack)
   );

`ifdef SB_I2C_CTRL_TIMEOUT_EN
   logic [15:0] r_poll;
   logic        w_init;
   logic        w_poll;

   assign w_init = (r_state == INIT_BRL) || (r_state == INIT_BRM)
                || (r_state == INIT_CR1);
   assign w_poll = (r_state == POLL_RDY) || (r_state == POLL_IDLE);

   // Counts status reads within one poll loop; cleared on any state move.
   always_ff @(posedge clk) begin
      if (reset || (w_next != r_state)) begin
         r_poll <= 16'd0;
      end else if (w_done) begin
         r_poll <= r_poll + 16'd1;
      end
   end
`else
   logic w_unused;
   assign w_unused = w_to ^ (^POLL_LIMIT);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= INIT_BRL;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_req      = 1'b0;
      w_rw       = 1'b0;
      w_nib      = REG_SR;
      w_wdat     = 8'h00;
      w_accept   = 1'b0;
      w_set_err  = 1'b0;
      w_set_nack = 1'b0;
      w_cap_rx   = 1'b0;
      unique case (r_state)
         INIT_BRL: begin
            w_req  = 1'b1;
            w_rw   = 1'b1;
            w_nib  = REG_BRLSB;
            w_wdat = PRESCALE[7:0];
            if (w_done) w_next = INIT_BRM;
         end
         INIT_BRM: begin
            w_req  = 1'b1;
            w_rw   = 1'b1;
            w_nib  = REG_BRMSB;
            w_wdat = {6'b0, PRESCALE[9:8]};
            if (w_done) w_next = INIT_CR1;
         end
         INIT_CR1: begin
            w_req  = 1'b1;
            w_rw   = 1'b1;
            w_nib  = REG_CR1;
            w_wdat = CR1_ENABLE;
            if (w_done) w_next = IDLE;
         end
         IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               w_next   = cmd_read ? WR_CMD : WR_TX;
            end
         end
         WR_TX: begin
            w_req  = 1'b1;
            w_rw   = 1'b1;
            w_nib  = REG_TXDR;
            w_wdat = r_data;
            if (w_done) w_next = WR_CMD;
         end
         WR_CMD: begin
            w_req  = 1'b1;
            w_rw   = 1'b1;
            w_nib  = REG_CMDR;
            w_wdat = r_read ? cmdr_byte(r_start, 1'b0, 1'b1, 1'b0, r_nack)
                            : cmdr_byte(r_start, 1'b0, 1'b0, 1'b1, 1'b0);
            if (w_done) w_next = POLL_RDY;
         end
         POLL_RDY: begin
            w_req = 1'b1;
            if (w_done) begin
               if (w_rd[SR_ARBL]) begin
                  w_set_err = 1'b1;
                  w_next    = RESP;
               end else if (w_rd[SR_TRRDY]) begin
                  w_set_nack = !r_read && w_rd[SR_RARC];
                  if (r_read)      w_next = RD_RX;
                  else if (r_stop) w_next = STOP_CMD;
                  else             w_next = RESP;
               end
            end
         end
         RD_RX: begin
            w_req = 1'b1;
            w_nib = REG_RXDR;
            if (w_done) begin
               w_cap_rx = 1'b1;
               w_next   = r_stop ? STOP_CMD : RESP;
            end
         end
         STOP_CMD: begin
            w_req  = 1'b1;
            w_rw   = 1'b1;
            w_nib  = REG_CMDR;
            w_wdat = cmdr_byte(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (w_done) w_next = POLL_IDLE;
         end
         POLL_IDLE: begin
            w_req = 1'b1;
            if (w_done) begin
               if (w_rd[SR_ARBL]) begin
                  w_set_err = 1'b1;
                  w_next    = RESP;
               end else if (!w_rd[SR_BUSY]) begin
                  w_next = RESP;
               end
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = INIT_BRL;
         end
      endcase
`ifdef SB_I2C_CTRL_TIMEOUT_EN
      if (w_done && w_to) begin
         w_set_err  = !w_init;
         w_set_nack = 1'b0;
         w_cap_rx   = 1'b0;
         w_next     = w_init ? INIT_BRL : RESP;
      end else if (w_done && w_poll && (w_next == r_state)
                   && (r_poll == POLL_LIMIT - 16'd1)) begin
         w_set_err = 1'b1;
         w_next    = RESP;
      end
`endif
   end

   // Results accumulate per command and publish on entry to RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_read      <= 1'b0;
         r_start     <= 1'b0;
         r_stop      <= 1'b0;
         r_nack      <= 1'b0;
         r_data      <= 8'h00;
         r_rx        <= 8'h00;
         r_nk_acc    <= 1'b0;
         r_err_acc   <= 1'b0;
         r_rsp_data  <= 8'h00;
         r_rsp_nack  <= 1'b0;
         r_rsp_error <= 1'b0;
      end else begin
         if (w_accept) begin
            r_read    <= cmd_read;
            r_start   <= cmd_start;
            r_stop    <= cmd_stop;
            r_nack    <= cmd_nack;
            r_data    <= cmd_data;
            r_rx      <= 8'h00;
            r_nk_acc  <= 1'b0;
            r_err_acc <= 1'b0;
         end
         if (w_set_err)  r_err_acc <= 1'b1;
         if (w_set_nack) r_nk_acc  <= 1'b1;
         if (w_cap_rx)   r_rx      <= w_rd;
         if ((w_next == RESP) && (r_state != RESP)) begin
            r_rsp_data  <= w_cap_rx ? w_rd : r_rx;
            r_rsp_nack  <= r_nk_acc | w_set_nack;
            r_rsp_error <= r_err_acc | w_set_err;
         end
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_rsp_data;
   assign rsp_nack  = r_rsp_nack;
   assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_sb_i2c_ctrl.sv
// Directed bench for sb_i2c_ctrl with a behavioural SB slave that
// logs every SB cycle as {rw, adr, data}.
module tb_sb_i2c_ctrl;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_read;
   logic       cmd_start;
   logic       cmd_stop;
   logic       cmd_nack;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_nack;
   logic       rsp_error;
   logic       sb_stb;
   logic       sb_rw;
   logic [7:0] sb_adr;
   logic [7:0] sb_dat_w;
   logic [7:0] sb_dat_r;
   logic       sb_ack;

   sb_i2c_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_read  (cmd_read),
      .cmd_start (cmd_start),
      .cmd_stop  (cmd_stop),
      .cmd_nack  (cmd_nack),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_nack  (rsp_nack),
      .rsp_error (rsp_error),
      .sb_stb    (sb_stb),
      .sb_rw     (sb_rw),
      .sb_adr    (sb_adr),
      .sb_dat_w  (sb_dat_w),
      .sb_dat_r  (sb_dat_r),
      .sb_ack    (sb_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic        hold_ack = 1'b0;
   logic [7:0]  rx_val = 8'h00;
   logic [7:0]  sr_q[$];
   logic [16:0] sb_log[$];

   typedef struct {
      logic            rd;
      logic            st;
      logic            sp;
      logic            nk;
      logic [7:0]      dat;
      int              sr_n;
      logic [3:0][7:0] sr;
      logic [7:0]      rx;
      int              exp_n;
      logic [5:0][16:0] exp_log;
      logic [7:0]      e_data;
      logic            e_nack;
      logic            e_err;
   } vec_t;

   vec_t tbl[6];

   function automatic logic [16:0] W(input logic [3:0] n, input logic [7:0] d);
      return {1'b1, 4'h1, n, d};
   endfunction

   function automatic logic [16:0] R(input logic [3:0] n, input logic [7:0] d);
      return {1'b0, 4'h1, n, d};
   endfunction

   // SB slave: acks one cycle after seeing the strobe, logs each cycle.
   initial begin
      sb_ack   = 1'b0;
      sb_dat_r = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (sb_ack) begin
            sb_ack = 1'b0;
         end else if (sb_stb && !hold_ack && !reset) begin
            if (!sb_rw) begin
               if (sb_adr[3:0] == 4'hE)  sb_dat_r = rx_val;
               else if (sr_q.size() > 0) sb_dat_r = sr_q.pop_front();
               else                      sb_dat_r = 8'h04;
            end
            sb_log.push_back({sb_rw, sb_adr, sb_rw ? sb_dat_w : sb_dat_r});
            sb_ack = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
   endtask

   task automatic wait_rsp();
      int k;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("rsp_valid_wait", {31'b0, rsp_valid}, 32'd1);
   endtask

   task automatic issue(input logic rd, input logic st, input logic sp,
                        input logic nk, input logic [7:0] d);
      cmd_read  = rd;
      cmd_start = st;
      cmd_stop  = sp;
      cmd_nack  = nk;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ready_drop", {31'b0, cmd_ready}, 32'd0);
   endtask

   task automatic check_init();
      logic [16:0] got;
      wait_ready();
      chk("init_count", sb_log.size(), 32'd3);
      got = (sb_log.size() > 0) ? sb_log[0] : 'x;
      chk("init_brlsb", got, W(4'hA, 8'h1E));
      got = (sb_log.size() > 1) ? sb_log[1] : 'x;
      chk("init_brmsb", got, W(4'hB, 8'h00));
      got = (sb_log.size() > 2) ? sb_log[2] : 'x;
      chk("init_cr1", got, W(4'h8, 8'h80));
   endtask

   task automatic check_reset_outputs();
      chk("reset_outs",
          {cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_error,
           sb_stb, sb_rw, sb_adr, sb_dat_w}, 32'd0);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      logic [16:0] got;
      v = tbl[i];
      sr_q.delete();
      for (int j = 0; j < v.sr_n; j++) sr_q.push_back(v.sr[j]);
      rx_val = v.rx;
      wait_ready();
      sb_log.delete();
      issue(v.rd, v.st, v.sp, v.nk, v.dat);
      wait_rsp();
      chk($sformatf("v%0d rsp_data", i), rsp_data, v.e_data);
      chk($sformatf("v%0d rsp_nack", i), rsp_nack, v.e_nack);
      chk($sformatf("v%0d rsp_error", i), rsp_error, v.e_err);
      chk($sformatf("v%0d sb_count", i), sb_log.size(), v.exp_n);
      for (int j = 0; j < v.exp_n; j++) begin
         got = (j < sb_log.size()) ? sb_log[j] : 'x;
         chk($sformatf("v%0d sb%0d", i, j), got, v.exp_log[j]);
      end
      @(negedge clk);
      chk($sformatf("v%0d pulse", i), {31'b0, rsp_valid}, 32'd0);
      chk($sformatf("v%0d hold", i), rsp_data, v.e_data);
      chk($sformatf("v%0d idle", i), {31'b0, cmd_ready}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) begin
         tbl[i] = '{rd: 0, st: 0, sp: 0, nk: 0, dat: 0, sr_n: 0, sr: '0,
                    rx: 0, exp_n: 0, exp_log: '0, e_data: 0, e_nack: 0,
                    e_err: 0};
      end
      // write A5 with START, one busy poll then TRRDY
      tbl[0].st = 1; tbl[0].dat = 8'hA5;
      tbl[0].sr_n = 1; tbl[0].sr[0] = 8'h80;
      tbl[0].exp_n = 4;
      tbl[0].exp_log[0] = W(4'hD, 8'hA5);
      tbl[0].exp_log[1] = W(4'h9, 8'h90);
      tbl[0].exp_log[2] = R(4'hC, 8'h80);
      tbl[0].exp_log[3] = R(4'hC, 8'h04);
      // write 5A with STOP, slave NACK, bus busy once
      tbl[1].sp = 1; tbl[1].dat = 8'h5A;
      tbl[1].sr_n = 2; tbl[1].sr[0] = 8'h24; tbl[1].sr[1] = 8'h44;
      tbl[1].exp_n = 6; tbl[1].e_nack = 1;
      tbl[1].exp_log[0] = W(4'hD, 8'h5A);
      tbl[1].exp_log[1] = W(4'h9, 8'h10);
      tbl[1].exp_log[2] = R(4'hC, 8'h24);
      tbl[1].exp_log[3] = W(4'h9, 8'h40);
      tbl[1].exp_log[4] = R(4'hC, 8'h44);
      tbl[1].exp_log[5] = R(4'hC, 8'h04);
      // read with NACK and STOP, RXDR = 3C
      tbl[2].rd = 1; tbl[2].nk = 1; tbl[2].sp = 1; tbl[2].rx = 8'h3C;
      tbl[2].exp_n = 5; tbl[2].e_data = 8'h3C;
      tbl[2].exp_log[0] = W(4'h9, 8'h28);
      tbl[2].exp_log[1] = R(4'hC, 8'h04);
      tbl[2].exp_log[2] = R(4'hE, 8'h3C);
      tbl[2].exp_log[3] = W(4'h9, 8'h40);
      tbl[2].exp_log[4] = R(4'hC, 8'h04);
      // arbitration lost on first poll: STOP skipped
      tbl[3].st = 1; tbl[3].sp = 1; tbl[3].dat = 8'h11;
      tbl[3].sr_n = 1; tbl[3].sr[0] = 8'h08;
      tbl[3].exp_n = 3; tbl[3].e_err = 1;
      tbl[3].exp_log[0] = W(4'hD, 8'h11);
      tbl[3].exp_log[1] = W(4'h9, 8'h90);
      tbl[3].exp_log[2] = R(4'hC, 8'h08);
      // read with START, ACK, no STOP
      tbl[4].rd = 1; tbl[4].st = 1; tbl[4].rx = 8'hC3;
      tbl[4].sr_n = 2; tbl[4].sr[0] = 8'h80; tbl[4].sr[1] = 8'h84;
      tbl[4].exp_n = 4; tbl[4].e_data = 8'hC3;
      tbl[4].exp_log[0] = W(4'h9, 8'hA0);
      tbl[4].exp_log[1] = R(4'hC, 8'h80);
      tbl[4].exp_log[2] = R(4'hC, 8'h84);
      tbl[4].exp_log[3] = R(4'hE, 8'hC3);
      // arbitration lost while waiting for bus idle
      tbl[5].st = 1; tbl[5].sp = 1; tbl[5].dat = 8'h00;
      tbl[5].sr_n = 2; tbl[5].sr[0] = 8'h04; tbl[5].sr[1] = 8'h48;
      tbl[5].exp_n = 5; tbl[5].e_err = 1;
      tbl[5].exp_log[0] = W(4'hD, 8'h00);
      tbl[5].exp_log[1] = W(4'h9, 8'h90);
      tbl[5].exp_log[2] = R(4'hC, 8'h04);
      tbl[5].exp_log[3] = W(4'h9, 8'h40);
      tbl[5].exp_log[4] = R(4'hC, 8'h48);

      cmd_valid = 0; cmd_read = 0; cmd_start = 0;
      cmd_stop = 0; cmd_nack = 0; cmd_data = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      sb_log.delete();
      reset = 1'b0;
      check_init();

      for (int i = 0; i < 6; i++) run_vec(i);

`ifdef SB_I2C_CTRL_TIMEOUT_EN
      begin
         int stb_cyc;
         int k;
         wait_ready();
         hold_ack = 1'b1;
         issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
         stb_cyc = 0;
         k = 0;
         while (rsp_valid !== 1'b1 && k < 2000) begin
            if (sb_stb) stb_cyc++;
            @(negedge clk);
            k++;
         end
         chk("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("to_stb_cycles", stb_cyc, 32'd255);
         chk("to_rsp_error", {31'b0, rsp_error}, 32'd1);
         chk("to_stb_low", {31'b0, sb_stb}, 32'd0);
         hold_ack = 1'b0;
      end
`endif

      // reset in the middle of an SB cycle, then init must rerun
      begin
         int k;
         wait_ready();
         hold_ack = 1'b1;
         issue(1'b0, 1'b1, 1'b1, 1'b0, 8'h42);
         k = 0;
         while (sb_stb !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("mid_stb_seen", {31'b0, sb_stb}, 32'd1);
         reset = 1'b1;
         @(negedge clk);
         check_reset_outputs();
         hold_ack = 1'b0;
         sb_log.delete();
         reset = 1'b0;
         check_init();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
